hazard_unit: RTL
================

# hazard_unit

Pipeline hazard and stall controller for the 5-stage core (F/D/E/M/W; 20-bit instructions, 19-bit registers, 15-bit PC, 5-bit register addresses).
- Computes E-stage operand forwarding selects.
- Inserts load-use bubbles and flushes D/E on taken branch or jump.
- Freezes the pipeline while the multi-cycle data memory is busy.
- Keeps a saturating stall-cycle counter for performance debug.

## Interface
- MEM_TIMEOUT, 15: max consecutive MEM_WAIT cycles before error (≥1).
- CNT_W, 16: stall counter width.
- clk  in  1  core clock; single clock domain.
- reset  in  1  synchronous, active-high.
- Rs1D, Rs2D  in  5  source registers of instruction in D.
- Rs1E, Rs2E, RdE  in  5  sources/destination of instruction in E.
- RdM, RdW  in  5  destinations in M and W.
- RegWriteE, RegWriteM, RegWriteW  in  1  stage writes a register.
- ResultSrcE  in  1  1 = instruction in E is a load.
- PCSrcE  in  1  taken branch/jump resolved in E.
- MemReqM, MemReadyM  in  1  data-memory request in M / memory ready.
- ForwardAE, ForwardBE  out  2  operand A/B select: 00 register file, 01 ResultW, 10 ALUResultM.
- StallF, StallD, StallE, StallM  out  1  hold stage register.
- FlushD, FlushE, FlushW  out  1  clear stage register (bubble).
- MemErr  out  1  sticky memory timeout flag.
- StallCount  out  CNT_W  cycles with StallF high, saturating.

## Operation
- Forwarding (per operand, e.g. A with Rs1E):
  - 10 if RegWriteM and RdM≠0 and RdM==Rs1E.
  - Else 01 if RegWriteW and RdW≠0 and RdW==Rs1E.
  - Else 00. M has priority over W. Register 0 never forwards.
- Load-use: ResultSrcE and RegWriteE and RdE≠0 and (RdE==Rs1D or RdE==Rs2D) → StallF=StallD=FlushE=1 (one bubble).
- Control hazard: PCSrcE → FlushD=FlushE=1. Overrides load-use: StallF=StallD=0 that cycle.
- FSM states RUN, MEM_WAIT, MEM_ERR:
  - RUN: MemReqM and !MemReadyM → MEM_WAIT, timeout counter := 1.
  - MEM_WAIT: MemReadyM → RUN. Otherwise counter++, and counter==MEM_TIMEOUT → MEM_ERR.
  - MEM_ERR: stays until reset; MemErr=1.
- Memory stall condition: (RUN and MemReqM and !MemReadyM), or state==MEM_WAIT and !MemReadyM, or state==MEM_ERR. When true:
  - StallF/D/E/M=1, FlushW=1.
  - FlushD=FlushE=0; PCSrcE and load-use are ignored.
  - ForwardAE/BE are still computed normally.
- StallCount increments on every cycle StallF=1 and holds at all-ones.

## Timing
- Forward, stall and flush outputs are combinational from inputs and current state; zero latency, valid in the same cycle.
- FSM, timeout counter and StallCount update on the rising clk edge.
- MemReadyM in the same cycle as MemReqM: no stall.
- In MEM_WAIT, the cycle MemReadyM rises has stalls deasserted, so the pipeline advances that edge.
- Memory latency of N cycles (ready on the Nth cycle after the request) gives N stall cycles, provided N<MEM_TIMEOUT.
- Reset:
  - While reset is high, every output is 0 and Forward selects are 00.
  - Next edge: state=RUN, counters=0, MemErr=0.
  - Reset mid-MEM_WAIT or in MEM_ERR returns to RUN with no residual stall.

## Structure
- Package hazard_pkg: fwd_sel_t enum (FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10), mem_state_t enum (RUN, MEM_WAIT, MEM_ERR), REG_AW=5.
- Sub-module forward_unit: one operand's select logic, instantiated twice (A, B).

## Test plan
- Forwarding: Rs1E=3, RdM=3/RegWriteM=1, RdW=3/RegWriteW=1 → ForwardAE=10. Drop RegWriteM → 01. Rs2E=0 with RdM=0 → ForwardBE=00.
- Load-use: ResultSrcE=1, RegWriteE=1, RdE=5, Rs2D=5 → StallF=StallD=FlushE=1 for exactly one cycle. Add PCSrcE=1 → FlushD=FlushE=1, StallF=0.
- Memory wait: MemReqM=1, MemReadyM rises 3 cycles later → StallF/D/E/M and FlushW high 3 cycles, StallCount=3, state back to RUN. PCSrcE pulsed during the wait → FlushD stays 0.
- Timeout: MemReqM=1, MemReadyM held 0 → MemErr=1 after 15 cycles in MEM_WAIT, stalls held. Reset → all outputs 0, MemErr=0.
- Saturation: CNT_W=4, 20 stall cycles → StallCount=15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// memory-wait FSM states and the register-match helper used by forwarding.
package hazard_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_ERR  = 2'b10
  } mem_state_t;

  // A later stage supplies a source operand only if it writes a non-zero register matching it.
  function automatic logic regHit(
    input logic              regWrite,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] rs
  );
    return regWrite && (rd != {REG_AW{1'b0}}) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one E-stage source register.
// The M stage holds the younger result, so it wins over W.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output fwd_sel_t          Forward
);

  // Priority select: M result, then W result, then register file.
  always_comb begin
    Forward = FWD_REG;
    if (regHit(RegWriteM, RdM, RsE)) begin
      Forward = FWD_M;
    end else if (regHit(RegWriteW, RdW, RsE)) begin
      Forward = FWD_W;
    end else begin
      Forward = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and stall controller for the 5-stage core: forwarding, load-use
// bubbles, branch flushes, data-memory freeze with timeout, stall counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemErr,
  output logic [CNT_W-1:0]  StallCount
);

  // One spare bit keeps the increment well-formed even for MEM_TIMEOUT = 1.
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1) + 1;

  mem_state_t       stateR;
  mem_state_t       stateNextS;
  logic [TO_W-1:0]  toCntR;
  logic [TO_W-1:0]  toCntNextS;
  logic [CNT_W-1:0] stallCountR;
  logic             memStallS;
  logic             loadUseS;
  fwd_sel_t         fwdAS;
  fwd_sel_t         fwdBS;

  forward_unit uFwdA (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (fwdAS)
  );

  forward_unit uFwdB (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (fwdBS)
  );

  // Memory-wait FSM and timeout counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR <= RUN;
      toCntR <= {TO_W{1'b0}};
    end else begin
      stateR <= stateNextS;
      toCntR <= toCntNextS;
    end
  end

  // Next state: the counter holds the number of MEM_WAIT cycles seen so far.
  always_comb begin
    stateNextS = stateR;
    toCntNextS = toCntR;
    case (stateR)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          stateNextS = MEM_WAIT;
          toCntNextS = TO_W'(1);
        end else begin
          stateNextS = RUN;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          stateNextS = RUN;
          toCntNextS = {TO_W{1'b0}};
        end else if (toCntR == TO_W'(MEM_TIMEOUT)) begin
          stateNextS = MEM_ERR;
        end else begin
          toCntNextS = toCntR + TO_W'(1);
        end
      end
      MEM_ERR: begin
        stateNextS = MEM_ERR;
      end
      default: begin
        stateNextS = RUN;
        toCntNextS = {TO_W{1'b0}};
      end
    endcase
  end

  // Hazard detection; the ready cycle of a wait is already a non-stall cycle.
  always_comb begin
    memStallS = 1'b0;
    case (stateR)
      RUN:      memStallS = MemReqM && !MemReadyM;
      MEM_WAIT: memStallS = !MemReadyM;
      MEM_ERR:  memStallS = 1'b1;
      default:  memStallS = 1'b0;
    endcase
    loadUseS = ResultSrcE && RegWriteE && (RdE != {REG_AW{1'b0}}) &&
               ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // Stall/flush/forward outputs; memory freeze dominates branch, branch dominates load-use.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (reset) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else begin
      ForwardAE = fwdAS;
      ForwardBE = fwdBS;
      if (memStallS) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (loadUseS) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else begin
        StallF = 1'b0;
      end
    end
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCountR <= {CNT_W{1'b0}};
    end else if (StallF && (stallCountR != {CNT_W{1'b1}})) begin
      stallCountR <= stallCountR + CNT_W'(1);
    end else begin
      stallCountR <= stallCountR;
    end
  end

  assign MemErr     = !reset && (stateR == MEM_ERR);
  assign StallCount = reset ? {CNT_W{1'b0}} : stallCountR;

endmodule
